// File: rtl/int_ctrl.sv
// Interrupt controller / exception-state unit feeding the next-PC stage.
// Synchronises, latches, masks and prioritises interrupt lines; tracks EXL through MRET.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | normal execution, interrupts may be taken
// ST_HANDLER | inside the handler, new requests only latch into pending
// ST_RETURN  | one-cycle MRET shadow so the resumed instruction is fetched
module int_ctrl #(
  parameter int          NUM_SRC       = 3,
  parameter logic [31:0] RESET_PC_SEPC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [31:0]        epc_in,
  input  logic               take_ok,
  input  logic               mret,
  input  logic               csr_we,
  input  logic [1:0]         csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               int_signal,
  output logic               exl_set,
  output logic [NUM_SRC-1:0] int_pend,
  output logic [31:0]        sepc,
  output logic [1:0]         int_cause
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MIE   = 2'd0;
  localparam logic [1:0] ADDR_SEPC  = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;
  localparam logic [1:0] ADDR_PEND  = 2'd3;

  state_t state, state_nxt;

  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] pending, pending_nxt;
  logic [NUM_SRC-1:0] mask;
  logic               gie;
  logic [31:0]        sepc_nxt;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] win_onehot;
  logic [1:0]         win_idx;
  logic [NUM_SRC-1:0] take_clr;
  logic [NUM_SRC-1:0] w1c_clr;
  logic               wr_mie, wr_sepc, wr_pend;

  assign rise       = sync2 & ~sync3;
  assign int_pend   = pending & mask;
  assign int_signal = (state == ST_IDLE) & gie & (|int_pend) & take_ok;

  assign wr_mie  = csr_we & (csr_addr == ADDR_MIE);
  assign wr_sepc = csr_we & (csr_addr == ADDR_SEPC);
  assign wr_pend = csr_we & (csr_addr == ADDR_PEND);

  // Scan from the top down so the lowest-numbered source ends up the winner.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (int_pend[i]) begin
        win_idx       = 2'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign take_clr = int_signal ? win_onehot : '0;
  assign w1c_clr  = wr_pend ? csr_wdata[NUM_SRC-1:0] : '0;

  // A fresh edge always beats a clear landing in the same cycle.
  assign pending_nxt = (pending & ~take_clr & ~w1c_clr) | rise;

  always_comb begin
    sepc_nxt = sepc;
    if (int_signal)
      sepc_nxt = epc_in;
    else if (wr_sepc)
      sepc_nxt = csr_wdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (int_signal) state_nxt = ST_HANDLER;
      ST_HANDLER: if (mret)       state_nxt = ST_RETURN;
      ST_RETURN:                  state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      pending   <= '0;
      mask      <= '0;
      gie       <= 1'b0;
      sepc      <= RESET_PC_SEPC;
      int_cause <= '0;
      exl_set   <= 1'b0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= pending_nxt;
      sepc    <= sepc_nxt;
      exl_set <= (state_nxt != ST_IDLE);
      if (wr_mie) begin
        mask <= csr_wdata[NUM_SRC-1:0];
        gie  <= csr_wdata[31];
      end
      if (int_signal)
        int_cause <= win_idx;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MIE:   csr_rdata = {gie, {(31 - NUM_SRC){1'b0}}, mask};
      ADDR_SEPC:  csr_rdata = sepc;
      ADDR_CAUSE: csr_rdata = {exl_set, 29'b0, int_cause};
      ADDR_PEND:  csr_rdata = {{(32 - NUM_SRC){1'b0}}, pending};
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then a random
// run checked against an event-history reference model.
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  irq_in;
  logic [31:0] epc_in;
  logic        take_ok;
  logic        mret;
  logic        csr_we;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        int_signal;
  logic        exl_set;
  logic [2:0]  int_pend;
  logic [31:0] sepc;
  logic [1:0]  int_cause;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.NUM_SRC(3), .RESET_PC_SEPC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .epc_in     (epc_in),
    .take_ok    (take_ok),
    .mret       (mret),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .int_signal (int_signal),
    .exl_set    (exl_set),
    .int_pend   (int_pend),
    .sepc       (sepc),
    .int_cause  (int_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raw line history per clock edge, pending as a set of
  // requests, and a handler mode (0 running, 1 in handler, 2 returning).
  localparam int LOG_N = 1024;
  bit [2:0]  irq_log [LOG_N];
  int        edge_n = 3;
  bit [2:0]  m_pend;
  bit [2:0]  m_mask;
  bit        m_gie;
  bit [31:0] m_sepc;
  bit [1:0]  m_cause;
  int        m_mode;

  function automatic bit [2:0] m_ipend();
    return m_pend & m_mask;
  endfunction

  function automatic bit m_take();
    return (m_mode == 0) && m_gie && (m_ipend() != 0) && take_ok;
  endfunction

  function automatic int m_winner();
    bit [2:0] p;
    p = m_ipend();
    for (int i = 0; i < 3; i++)
      if (p[i]) return i;
    return 0;
  endfunction

  function automatic bit [31:0] m_rdata(input bit [1:0] a);
    case (a)
      2'd0:    return {m_gie, 28'b0, m_mask};
      2'd1:    return m_sepc;
      2'd2:    return {(m_mode != 0), 29'b0, m_cause};
      default: return {29'b0, m_pend};
    endcase
  endfunction

  task automatic model_edge();
    bit [2:0] rose;
    bit [2:0] clr;
    bit       tk;
    int       w;
    edge_n++;
    irq_log[edge_n % LOG_N] = irq_in;
    if (rst) begin
      irq_log[edge_n % LOG_N]       = '0;
      irq_log[(edge_n - 1) % LOG_N] = '0;
      irq_log[(edge_n - 2) % LOG_N] = '0;
      m_pend = '0; m_mask = '0; m_gie = 1'b0;
      m_sepc = '0; m_cause = '0; m_mode = 0;
    end else begin
      // A rise is seen three edges after the line was first sampled high.
      rose = irq_log[(edge_n - 2) % LOG_N] & ~irq_log[(edge_n - 3) % LOG_N];
      tk   = m_take();
      w    = m_winner();
      clr  = '0;
      if (csr_we && csr_addr == 2'd0) begin
        m_mask = csr_wdata[2:0];
        m_gie  = csr_wdata[31];
      end
      if (csr_we && csr_addr == 2'd1) m_sepc = csr_wdata;
      if (csr_we && csr_addr == 2'd3) clr = csr_wdata[2:0];
      if (tk) begin
        m_sepc   = epc_in;
        m_cause  = 2'(w);
        clr[w]   = 1'b1;
        m_mode   = 1;
      end else if (m_mode == 1 && mret) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
      m_pend = (m_pend & ~clr) | rose;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic csr_write(input bit [1:0] a, input bit [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    cycle();
    csr_we = 1'b0;
  endtask

  task automatic rise_line(input bit [2:0] lines);
    irq_in = lines;
    cycle();
    irq_in = '0;
    cycle();
    cycle();
  endtask

  task automatic leave_handler();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    irq_in = 3'b111;
    cycle();
    rst = 1'b0;
    irq_in = '0;
    n_vec++; if (exl_set !== 1'b0) begin n_err++; $display("FAIL reset_exl got %b want 0", exl_set); end
    n_vec++; if (sepc !== 32'h0) begin n_err++; $display("FAIL reset_sepc got %h want 0", sepc); end
    n_vec++; if (int_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause got %0d want 0", int_cause); end
    n_vec++; if (int_pend !== 3'b000) begin n_err++; $display("FAIL reset_int_pend got %b want 000", int_pend); end
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL reset_int_signal got %b want 0", int_signal); end
    for (int a = 0; a < 4; a++) begin
      csr_addr = 2'(a);
      #1;
      n_vec++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_csr%0d got %h want 0", a, csr_rdata); end
    end
  endtask

  task automatic test_basic_take();
    csr_write(2'd0, 32'h8000_0007);
    epc_in = 32'h0000_0040;
    take_ok = 1'b1;
    irq_in = 3'b010;
    cycle();
    irq_in = '0;
    cycle();
    n_vec++; if (int_pend !== 3'b000) begin n_err++; $display("FAIL basic_early_pend got %b want 000", int_pend); end
    cycle();
    n_vec++; if (int_pend !== 3'b010) begin n_err++; $display("FAIL basic_pend got %b want 010", int_pend); end
    n_vec++; if (int_signal !== 1'b1) begin n_err++; $display("FAIL basic_int_signal got %b want 1", int_signal); end
    cycle();
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL basic_one_shot got %b want 0", int_signal); end
    n_vec++; if (sepc !== 32'h40) begin n_err++; $display("FAIL basic_sepc got %h want 40", sepc); end
    n_vec++; if (int_cause !== 2'd1) begin n_err++; $display("FAIL basic_cause got %0d want 1", int_cause); end
    n_vec++; if (exl_set !== 1'b1) begin n_err++; $display("FAIL basic_exl got %b want 1", exl_set); end
    csr_addr = 2'd2;
    #1;
    n_vec++; if (csr_rdata !== 32'h8000_0001) begin n_err++; $display("FAIL basic_cause_csr got %h want 80000001", csr_rdata); end
    csr_addr = 2'd3;
    #1;
    n_vec++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL basic_pend_csr got %h want 0", csr_rdata); end
    leave_handler();
    n_vec++; if (exl_set !== 1'b0) begin n_err++; $display("FAIL basic_exit_exl got %b want 0", exl_set); end
  endtask

  task automatic test_priority_tail();
    rise_line(3'b101);
    n_vec++; if (int_pend !== 3'b101) begin n_err++; $display("FAIL prio_pend got %b want 101", int_pend); end
    cycle();
    n_vec++; if (int_cause !== 2'd0) begin n_err++; $display("FAIL prio_cause got %0d want 0", int_cause); end
    n_vec++; if (int_pend !== 3'b100) begin n_err++; $display("FAIL prio_left got %b want 100", int_pend); end
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL prio_handler_sig got %b want 0", int_signal); end
    epc_in = 32'h0000_0088;
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    n_vec++; if (exl_set !== 1'b1) begin n_err++; $display("FAIL prio_return_exl got %b want 1", exl_set); end
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL prio_return_sig got %b want 0", int_signal); end
    cycle();
    n_vec++; if (exl_set !== 1'b0) begin n_err++; $display("FAIL prio_idle_exl got %b want 0", exl_set); end
    n_vec++; if (int_signal !== 1'b1) begin n_err++; $display("FAIL prio_tail_sig got %b want 1", int_signal); end
    cycle();
    n_vec++; if (int_cause !== 2'd2) begin n_err++; $display("FAIL prio_tail_cause got %0d want 2", int_cause); end
    n_vec++; if (sepc !== 32'h88) begin n_err++; $display("FAIL prio_tail_sepc got %h want 88", sepc); end
    leave_handler();
  endtask

  task automatic test_mask_defer();
    csr_write(2'd0, 32'h8000_0005);
    rise_line(3'b010);
    n_vec++; if (int_pend !== 3'b000) begin n_err++; $display("FAIL mask_int_pend got %b want 000", int_pend); end
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL mask_sig got %b want 0", int_signal); end
    csr_addr = 2'd3;
    #1;
    n_vec++; if (csr_rdata !== 32'h2) begin n_err++; $display("FAIL mask_raw_pend got %h want 2", csr_rdata); end
    csr_write(2'd3, 32'h2);
    csr_write(2'd0, 32'h8000_0007);
    take_ok = 1'b0;
    epc_in = 32'h0000_0200;
    rise_line(3'b001);
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL defer_sig[%0d] got %b want 0", k, int_signal); end
      n_vec++; if (int_pend !== 3'b001) begin n_err++; $display("FAIL defer_pend[%0d] got %b want 001", k, int_pend); end
      cycle();
    end
    take_ok = 1'b1;
    #1;
    n_vec++; if (int_signal !== 1'b1) begin n_err++; $display("FAIL defer_release got %b want 1", int_signal); end
    cycle();
    n_vec++; if (sepc !== 32'h200) begin n_err++; $display("FAIL defer_sepc got %h want 200", sepc); end
    leave_handler();
  endtask

  task automatic test_collision();
    csr_write(2'd0, 32'h0000_0007);
    rise_line(3'b001);
    cycle();
    csr_addr = 2'd3;
    #1;
    n_vec++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL coll_setup got %h want 1", csr_rdata); end
    irq_in = 3'b001;
    cycle();
    cycle();
    irq_in = '0;
    csr_we = 1'b1; csr_addr = 2'd3; csr_wdata = 32'h1;
    cycle();
    csr_we = 1'b0;
    #1;
    n_vec++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL coll_set_wins got %h want 1", csr_rdata); end
    csr_write(2'd3, 32'h1);
    #1;
    n_vec++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL coll_w1c got %h want 0", csr_rdata); end
  endtask

  task automatic test_mret_cases();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    n_vec++; if (exl_set !== 1'b0) begin n_err++; $display("FAIL stray_exl got %b want 0", exl_set); end
    n_vec++; if (int_cause !== 2'd0) begin n_err++; $display("FAIL stray_cause got %0d want 0", int_cause); end
    n_vec++; if (sepc !== 32'h200) begin n_err++; $display("FAIL stray_sepc got %h want 200", sepc); end
    csr_write(2'd0, 32'h8000_0007);
    epc_in = 32'h0000_0300;
    rise_line(3'b100);
    cycle();
    n_vec++; if (int_cause !== 2'd2) begin n_err++; $display("FAIL mp_cause got %0d want 2", int_cause); end
    n_vec++; if (sepc !== 32'h300) begin n_err++; $display("FAIL mp_sepc got %h want 300", sepc); end
    rise_line(3'b010);
    n_vec++; if (int_pend !== 3'b010) begin n_err++; $display("FAIL mp_pend got %b want 010", int_pend); end
    mret = 1'b1;
    #1;
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL mp_handler_sig got %b want 0", int_signal); end
    cycle();
    mret = 1'b0;
    n_vec++; if (int_signal !== 1'b0) begin n_err++; $display("FAIL mp_return_sig got %b want 0", int_signal); end
    n_vec++; if (exl_set !== 1'b1) begin n_err++; $display("FAIL mp_return_exl got %b want 1", exl_set); end
    cycle();
    n_vec++; if (int_signal !== 1'b1) begin n_err++; $display("FAIL mp_idle_sig got %b want 1", int_signal); end
    cycle();
    n_vec++; if (int_cause !== 2'd1) begin n_err++; $display("FAIL mp_tail_cause got %0d want 1", int_cause); end
  endtask

  task automatic test_reset_mid();
    csr_write(2'd1, 32'h0000_0100);
    n_vec++; if (sepc !== 32'h100) begin n_err++; $display("FAIL mid_sepc_wr got %h want 100", sepc); end
    rise_line(3'b001);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_vec++; if (exl_set !== 1'b0) begin n_err++; $display("FAIL mid_exl got %b want 0", exl_set); end
    n_vec++; if (sepc !== 32'h0) begin n_err++; $display("FAIL mid_sepc got %h want 0", sepc); end
    for (int a = 0; a < 4; a++) begin
      csr_addr = 2'(a);
      #1;
      n_vec++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL mid_csr%0d got %h want 0", a, csr_rdata); end
    end
  endtask

  task automatic test_random();
    bit [31:0] d;
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      take_ok  = ($urandom_range(0, 3) != 0);
      mret     = ($urandom_range(0, 5) == 0);
      epc_in   = $urandom;
      csr_addr = 2'($urandom_range(0, 3));
      csr_we   = ($urandom_range(0, 7) == 0);
      d = $urandom;
      if (csr_addr == 2'd0) d[31] = ($urandom_range(0, 3) != 0);
      csr_wdata = d;
      #1;
      n_vec++; if (int_signal !== m_take()) begin n_err++; $display("FAIL rnd_sig[%0d] got %b want %b", k, int_signal, m_take()); end
      n_vec++; if (int_pend !== m_ipend()) begin n_err++; $display("FAIL rnd_pend[%0d] got %b want %b", k, int_pend, m_ipend()); end
      n_vec++; if (csr_rdata !== m_rdata(csr_addr)) begin n_err++; $display("FAIL rnd_csr[%0d] got %h want %h", k, csr_rdata, m_rdata(csr_addr)); end
      cycle();
      n_vec++; if (exl_set !== (m_mode != 0)) begin n_err++; $display("FAIL rnd_exl[%0d] got %b want %b", k, exl_set, (m_mode != 0)); end
      n_vec++; if (sepc !== m_sepc) begin n_err++; $display("FAIL rnd_sepc[%0d] got %h want %h", k, sepc, m_sepc); end
      n_vec++; if (int_cause !== m_cause) begin n_err++; $display("FAIL rnd_cause[%0d] got %0d want %0d", k, int_cause, m_cause); end
    end
    rst = 1'b0; csr_we = 1'b0; mret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; epc_in = '0; take_ok = 1'b0; mret = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    @(negedge clk);
    test_reset();
    test_basic_take();
    test_priority_tail();
    test_mask_defer();
    test_collision();
    test_mret_cases();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller and exception-state unit that sits directly upstream of the next-PC stage. It synchronises and latches three external interrupt lines, masks and prioritises them, and decides the cycle in which the pipeline is redirected to the interrupt vector. It saves the resume PC and tracks the in-handler (EXL) state through MRET. It drives the next-PC stage's int_signal, exl_set, int_pend, sepc and consumes the same mret strobe.

Parameters:
NUM_SRC, 3, number of interrupt sources (fixed at 3; the int_pend width matches the next-PC stage).
RESET_PC_SEPC, 32'h0000_0000, reset value of the SEPC register.

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
irq_in  in  3  raw interrupt request lines, asynchronous to clk
epc_in  in  32  PC of the oldest unretired instruction (resume address), from the pipeline
take_ok  in  1  pipeline is at a precise point: PC write enabled, no flush or redirect in flight
mret  in  1  MRET is being executed this cycle (same strobe the next-PC stage sees)
csr_we  in  1  CSR write enable
csr_addr  in  2  0=MIE, 1=SEPC, 2=CAUSE, 3=PEND
csr_wdata  in  32  CSR write data
csr_rdata  out  32  CSR read data, combinational from csr_addr
int_signal  out  1  redirect to the interrupt vector this cycle (combinational)
exl_set  out  1  handler-active status bit (registered)
int_pend  out  3  pending AND mask (registered pending, combinational AND)
sepc  out  32  saved exception PC (registered)
int_cause  out  2  index of the last taken source (registered)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pending=0, sync flops=0, MIE=0 (mask=0, GIE=0), sepc=RESET_PC_SEPC, int_cause=0, exl_set=0. Outputs after reset: int_signal=0, int_pend=0. Reset mid-handler discards everything.
- Input path: each irq_in bit passes through a 2-flop synchroniser and then a rising-edge detector (third flop).
  - A detected edge sets pending[i] 3 cycles after irq_in rises.
  - Pending stays set until the interrupt is taken or cleared by a W1C write. Level-high lines do not re-set it.
- MIE register: bits[2:0]=mask, bit[31]=GIE; all other bits read 0.
- int_pend = pending & mask.
- int_signal = (state==IDLE) & GIE & |int_pend & take_ok. It is purely combinational so the next-PC stage redirects in the same cycle.
- Priority: source 0 is highest, then 1, then 2.
- At an edge where int_signal=1:
  - sepc<=epc_in.
  - int_cause<=winning index.
  - pending[winner]<=0; other pending bits are kept.
  - state<=HANDLER; exl_set<=1.
- FSM:
  - IDLE -> HANDLER on a taken interrupt.
  - HANDLER -> RETURN when mret=1.
  - RETURN -> IDLE unconditionally after 1 cycle.
  - mret in IDLE or RETURN is ignored (no state change).
  - exl_set=1 in HANDLER and RETURN, 0 in IDLE.
  - RETURN blocks interrupts for one cycle so at least the resumed instruction is fetched before re-entry.
- Interrupts arriving while in HANDLER/RETURN only set pending. They are taken (tail-chained) in the first IDLE cycle with take_ok=1.
- take_ok=0 defers the take indefinitely. Pending is preserved and int_signal stays 0.
- Simultaneous events:
  - A new edge on source i in the same cycle its pending bit is cleared (by take or W1C): the set wins and pending[i]=1 afterwards.
  - CSR write to SEPC in the same cycle as a take: the take's capture wins.
  - mret and a pending interrupt in the same HANDLER cycle: no take; MRET is processed.
- CSR writes (take effect next cycle):
  - MIE: written fully.
  - SEPC: written fully, allowed in any state.
  - CAUSE: read-only; writes are ignored.
  - PEND: write-1-to-clear on bits[2:0].
- CSR reads: CAUSE = {exl_set, 29'b0, int_cause}; PEND = {29'b0, pending}.

Test Plan:
- Basic take: reset, then write MIE=32'h8000_0007, pulse irq_in[1], hold take_ok=1, epc_in=32'h0000_0040 -> pending[1] set 3 cycles after the rise; int_signal=1 for exactly one cycle; then sepc=0x40, int_cause=1, exl_set=1, pending[1]=0.
- Priority and tail-chain: raise irq_in[2] and irq_in[0] together -> source 0 taken first (int_cause=0). Assert mret -> exl_set stays 1 for the RETURN cycle, then 0. Source 2 is taken in the next cycle: int_cause=2, sepc=epc_in.
- Masking and deferral: with mask=3'b101 and irq_in[1] edge -> int_pend=0, no take. With GIE=1, mask=7, pending[0]=1, take_ok=0 for 5 cycles -> int_signal=0 throughout; int_signal=1 on the first take_ok=1 cycle.
- Set versus clear collision: W1C PEND=1 in the same cycle a new edge on source 0 is detected -> pending[0]=1 afterwards.
- Stray MRET and mret-versus-pending: mret in IDLE -> no state or output change. In HANDLER with pending[1] set, assert mret -> int_signal stays 0 during HANDLER and RETURN; the take occurs in the first IDLE cycle.
- Reset mid-handler: in HANDLER with sepc=0x100, assert rst for 1 cycle -> exl_set=0, sepc=0, pending=0, MIE=0, csr_rdata for CAUSE=0.
